// File: rtl/llc_input_arbiter.sv
// Four-channel LLC input arbiter: fixed priority with starvation boost, one
// grant held per core transaction until core_done.
module llc_input_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int STARVE_LIMIT = 8,
   parameter int CNT_W        = $clog2(STARVE_LIMIT + 1),
   parameter int IDX_W        = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [NUM_REQ-1:0] req_mask,
   output logic [NUM_REQ-1:0] req_ready,
   input  logic               core_idle,
   input  logic               core_done,
   output logic               grant_valid,
   output logic [IDX_W-1:0]   grant_idx,
   output logic [NUM_REQ-1:0] grant_onehot,
   output logic               grant_boosted,
   output logic               busy
);

   // Handshake: a channel is accepted in the cycle req_valid[i] & req_ready[i];
   // req_ready is at most one-hot and only ever asserted in IDLE.
   typedef enum logic {S_IDLE, S_BUSY} state_t;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   state_t             state_q, state_d;
   logic               gv_q, gv_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [NUM_REQ-1:0] oh_q, oh_d;
   logic               boost_q, boost_d;
   logic [CNT_W-1:0]   cnt_q [NUM_REQ];
   logic [CNT_W-1:0]   cnt_d [NUM_REQ];

   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] starving;
   logic [IDX_W-1:0]   win_idx;
   logic [NUM_REQ-1:0] win_onehot;
   logic               win_boost;
   logic               found;
   logic               fire;

   always_comb begin
      eligible   = req_valid & ~req_mask;
      starving   = '0;
      win_idx    = '0;
      win_onehot = '0;
      found      = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         starving[i] = eligible[i] && (cnt_q[i] >= LIMIT);
      end
      win_boost = |starving;
      // Starving channels override plain priority; lowest index wins in both cases.
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && (win_boost ? starving[i] : eligible[i])) begin
            win_idx = IDX_W'(i);
            found   = 1'b1;
         end
      end
      win_onehot[win_idx] = 1'b1;
      fire      = rst && (state_q == S_IDLE) && core_idle && (|eligible);
      req_ready = fire ? win_onehot : '0;

      state_d = state_q;
      gv_d    = gv_q;
      idx_d   = idx_q;
      oh_d    = oh_q;
      boost_d = boost_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (fire) begin
               state_d = S_BUSY;
               gv_d    = 1'b1;
               idx_d   = win_idx;
               oh_d    = win_onehot;
               boost_d = win_boost;
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (win_onehot[i])
                     cnt_d[i] = '0;
                  else if (eligible[i])
                     cnt_d[i] = (cnt_q[i] >= LIMIT) ? LIMIT : cnt_q[i] + CNT_W'(1);
                  else
                     cnt_d[i] = '0;
               end
            end
         end
         S_BUSY: begin
            if (core_done) begin
               state_d = S_IDLE;
               gv_d    = 1'b0;
               boost_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         gv_q    <= 1'b0;
         idx_q   <= '0;
         oh_q    <= '0;
         boost_q <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      end else begin
         state_q <= state_d;
         gv_q    <= gv_d;
         idx_q   <= idx_d;
         oh_q    <= oh_d;
         boost_q <= boost_d;
         for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign grant_valid   = gv_q;
   assign grant_idx     = idx_q;
   assign grant_onehot  = oh_q;
   assign grant_boosted = boost_q;
   assign busy          = (state_q == S_BUSY);

endmodule

// File: tb/tb_llc_input_arbiter.sv
// Directed bench for llc_input_arbiter: reset, priority, masking, starvation
// boost, hold-while-busy and reset during a grant.
module tb_llc_input_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req_valid;
   logic [3:0] req_mask;
   logic [3:0] req_ready;
   logic       core_idle;
   logic       core_done;
   logic       grant_valid;
   logic [1:0] grant_idx;
   logic [3:0] grant_onehot;
   logic       grant_boosted;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   llc_input_arbiter #(.NUM_REQ(4), .STARVE_LIMIT(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_mask      (req_mask),
      .req_ready     (req_ready),
      .core_idle     (core_idle),
      .core_done     (core_done),
      .grant_valid   (grant_valid),
      .grant_idx     (grant_idx),
      .grant_onehot  (grant_onehot),
      .grant_boosted (grant_boosted),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] oh(input int i);
      logic [3:0] v;
      v = 4'b0001 << i;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called one step after an edge in IDLE with inputs set; checks the
   // acceptance, the registered grant, and (if do_done) the release.
   task automatic grant(input string tag, input int ei, input logic eb, input bit do_done);
      #1;
      chk({tag, ".ready"}, 32'(req_ready), 32'(oh(ei)));
      tick();
      chk({tag, ".gv"},    32'(grant_valid), 32'd1);
      chk({tag, ".idx"},   32'(grant_idx), 32'(ei));
      chk({tag, ".oh"},    32'(grant_onehot), 32'(oh(ei)));
      chk({tag, ".boost"}, 32'(grant_boosted), 32'(eb));
      chk({tag, ".busy"},  32'(busy), 32'd1);
      chk({tag, ".rdy0"},  32'(req_ready), 32'd0);
      if (do_done) begin
         tick();
         core_done = 1'b1;
         #1;
         chk({tag, ".bubble"}, 32'(req_ready), 32'd0);
         tick();
         core_done = 1'b0;
         chk({tag, ".gv_off"},   32'(grant_valid), 32'd0);
         chk({tag, ".busy_off"}, 32'(busy), 32'd0);
         chk({tag, ".bst_off"},  32'(grant_boosted), 32'd0);
         chk({tag, ".idx_keep"}, 32'(grant_idx), 32'(ei));
      end
   endtask

   initial begin
      rst       = 1'b0;
      req_valid = 4'b1111;
      req_mask  = 4'b0000;
      core_idle = 1'b1;
      core_done = 1'b0;

      // Reset held for three cycles with every channel requesting.
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rst.ready", 32'(req_ready), 32'd0);
         chk("rst.gv",    32'(grant_valid), 32'd0);
         chk("rst.busy",  32'(busy), 32'd0);
      end
      rst = 1'b1;
      grant("rst_rel", 0, 1'b0, 1'b1);

      // Priority.
      req_valid = 4'b1110;
      grant("prio1", 1, 1'b0, 1'b1);
      req_valid = 4'b1100;
      grant("prio2", 2, 1'b0, 1'b1);

      // Mask blocks the higher-priority channel.
      req_valid = 4'b0101;
      req_mask  = 4'b0001;
      grant("mask", 2, 1'b0, 1'b1);

      // Hold while busy: inputs wander, grant must not move.
      req_valid = 4'b1000;
      req_mask  = 4'b0000;
      grant("hold", 3, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         req_valid = 4'($urandom_range(0, 15));
         req_mask  = 4'($urandom_range(0, 15));
         #1;
         chk("hold.ready", 32'(req_ready), 32'd0);
         tick();
         chk("hold.idx",  32'(grant_idx), 32'd3);
         chk("hold.busy", 32'(busy), 32'd1);
      end
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      chk("hold.release", 32'(grant_valid), 32'd0);

      // core_done in IDLE with core_idle low is ignored.
      req_valid = 4'b0001;
      req_mask  = 4'b0000;
      core_idle = 1'b0;
      core_done = 1'b1;
      #1;
      chk("idle_done.ready", 32'(req_ready), 32'd0);
      tick();
      core_done = 1'b0;
      chk("idle_done.busy", 32'(busy), 32'd0);
      chk("idle_done.gv",   32'(grant_valid), 32'd0);
      core_idle = 1'b1;
      grant("idle_resume", 0, 1'b0, 1'b1);

      // Starvation from a clean reset: 8 wins for ch0, boosted ch2, then ch0.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      req_valid = 4'b0101;
      for (int g = 0; g < 8; g++) grant("starve_a", 0, 1'b0, 1'b1);
      grant("starve_boost", 2, 1'b1, 1'b1);
      grant("starve_back", 0, 1'b0, 1'b1);

      // Build ch3 credit, leave ch2 with nonzero credit, reset while ch3 is granted.
      req_valid = 4'b1001;
      for (int g = 0; g < 8; g++) grant("starve3", 0, 1'b0, 1'b1);
      req_valid = 4'b1101;
      grant("boost3", 3, 1'b1, 1'b0);
      rst = 1'b0;
      tick();
      chk("midrst.gv",    32'(grant_valid), 32'd0);
      chk("midrst.busy",  32'(busy), 32'd0);
      chk("midrst.boost", 32'(grant_boosted), 32'd0);
      chk("midrst.oh",    32'(grant_onehot), 32'd0);
      chk("midrst.idx",   32'(grant_idx), 32'd0);
      rst = 1'b1;

      // Cleared counters mean ch2 needs a full eight losses again.
      req_valid = 4'b0101;
      for (int g = 0; g < 8; g++) grant("post_rst", 0, 1'b0, 1'b1);
      grant("post_rst_boost", 2, 1'b1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/llc_input_arbiter.md
Name: llc_input_arbiter

Overview:
Arbitrates the four LLC input channels into the single LLC core pipeline: reset/flush, coherence response, coherence request and DMA request.
- Grants one channel per core transaction, then holds that grant until the core signals the transaction is complete.
- Applies fixed priority, augmented by per-channel starvation counters so that low-priority channels (req_in, dma_req_in) cannot be locked out indefinitely.
- Sits between the channel input buffers and the core's DECODE stage; the core's stall flags feed per-channel mask inputs.

Parameters:
NUM_REQ, 4, number of requester channels; index 0 rst_tb, 1 rsp_in, 2 req_in, 3 dma_req_in (0 = highest priority).
STARVE_LIMIT, 8, number of lost arbitrations after which an eligible channel is boosted; legal range 1..255.
CNT_W, $clog2(STARVE_LIMIT+1), derived; width of each wait counter.
IDX_W, $clog2(NUM_REQ), derived; width of the grant index.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-channel request valid
req_mask  in  NUM_REQ  1 = channel blocked this cycle (req_stall, flush_stall, rst_stall)
req_ready  out  NUM_REQ  per-channel accept; one-hot or zero
core_idle  in  1  core is in DECODE and can accept a new transaction
core_done  in  1  single-cycle pulse: current transaction finished (UPDATE exit)
grant_valid  out  1  a transaction is currently granted
grant_idx  out  IDX_W  index of the granted channel
grant_onehot  out  NUM_REQ  one-hot form of grant_idx
grant_boosted  out  1  current grant was won through starvation boost
busy  out  1  arbiter is in BUSY

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst). rst sampled low at a rising edge forces:
  - state IDLE
  - all wait counters 0
  - grant_valid, grant_idx, grant_onehot, grant_boosted and busy all 0
  - req_ready 0 (combinational; gated by !rst)
- Eligible channel i: eligible[i] = req_valid[i] & !req_mask[i].
- Starving channel i: starving[i] = eligible[i] & (cnt[i] >= STARVE_LIMIT).
- Winner selection (combinational):
  - If any channel is starving, the winner is the lowest-index starving channel, and boost = 1.
  - Otherwise the winner is the lowest-index eligible channel, and boost = 0.
- State machine has two states, IDLE and BUSY.
- IDLE:
  - Arbitration fires when core_idle = 1 and any channel is eligible. In that cycle req_ready[winner] = 1 combinationally and all other ready bits are 0; the valid&ready handshake completes in this same cycle.
  - On the next edge the arbiter registers grant_idx, grant_onehot and grant_boosted, sets grant_valid = 1 and busy = 1, and moves to BUSY.
  - If no channel is eligible, or core_idle = 0, req_ready = 0 and the arbiter stays in IDLE.
  - core_done received in IDLE is ignored.
- BUSY:
  - req_ready = 0 throughout; grant outputs are held stable.
  - On core_done = 1, the next edge moves to IDLE with grant_valid, busy and grant_boosted = 0. grant_idx retains its last value.
  - Minimum one-cycle bubble between grants: no req_ready in the cycle core_done is seen.
- Wait counters are updated only on an arbitration-fire edge:
  - Winner's counter clears to 0.
  - Every other eligible channel increments its counter, saturating at STARVE_LIMIT.
  - Ineligible channels (not valid, or masked) clear to 0, so a masked channel loses its starvation credit.
  - On non-fire edges, counters hold.
- Latency: request presented in IDLE with core_idle = 1 is accepted in the same cycle; grant_valid rises 1 cycle later.
- Changes to req_valid or req_mask while BUSY have no effect on the current grant.
- Simultaneous core_done and rst low: reset wins.
- Reset mid-BUSY: the transaction is abandoned and the arbiter returns to IDLE; the core is reset by the same signal.
- All outputs are registered, except req_ready, which is combinational from state, core_idle, req_valid, req_mask and the counters.

Test Plan:
- Reset: hold rst = 0 for 3 cycles with all req_valid = 1 -> req_ready = 0, grant_valid = 0, busy = 0 throughout; first cycle after release with core_idle = 1 -> req_ready = 4'b0001.
- Priority: req_valid = 4'b1110, core_idle = 1 -> req_ready = 4'b0010 that cycle; next cycle grant_idx = 1, grant_onehot = 4'b0010, grant_valid = 1. Pulse core_done -> grant_valid = 0 after 1 cycle, then ch2 is granted.
- Mask: req_valid = 4'b0101, req_mask = 4'b0001 -> ch2 granted; ch0 counter stays 0.
- Starvation (STARVE_LIMIT = 8): ch0 and ch2 continuously valid, core_done pulsed 2 cycles after each grant -> grants 1-8 go to ch0, grant 9 goes to ch2 with grant_boosted = 1, grant 10 returns to ch0.
- Hold/ignore: in BUSY, toggle req_valid and req_mask randomly -> grant_idx stable and req_ready = 0 until core_done. core_done pulsed in IDLE with core_idle = 0 -> no state change.
- Reset mid-op: assert rst = 0 while BUSY with ch3 granted -> next edge grant_valid = 0, busy = 0, all counters 0.
